// File: rtl/uart_pkg.sv
// Shared constants and TX drain state encoding for the UART byte-buffering stage.
package uart_pkg;

  localparam int unsigned UART_FIFO_DEPTH_LOG2_DEFAULT = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_GUARD = 2'd2,
    ST_DRAIN = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_if.sv
// Handshake bundle between UART PHYs, serial_ctrl and uart_fifo.
interface uart_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2_DEFAULT
);
  localparam int unsigned CW = DEPTH_LOG2 + 1;

  logic              rxdReady_i;
  logic [BYTE_W-1:0] rxdData_i;
  logic              rxPop_i;
  logic [BYTE_W-1:0] rxData_o;
  logic              rxValid_o;
  logic [CW-1:0]     rxCount_o;
  logic              txPush_i;
  logic [BYTE_W-1:0] txData_i;
  logic              txReady_o;
  logic [CW-1:0]     txCount_o;
  logic              txdBusy_i;
  logic              txdStart_o;
  logic [BYTE_W-1:0] txdData_o;
  logic              ovClear_i;
  logic              overrun_o;
  logic              int_o;

  modport slave (
    input  rxdReady_i, rxdData_i, rxPop_i, txPush_i, txData_i, txdBusy_i, ovClear_i,
    output rxData_o, rxValid_o, rxCount_o, txReady_o, txCount_o, txdStart_o, txdData_o,
           overrun_o, int_o
  );

  modport master (
    output rxdReady_i, rxdData_i, rxPop_i, txPush_i, txData_i, txdBusy_i, ovClear_i,
    input  rxData_o, rxValid_o, rxCount_o, txReady_o, txCount_o, txdStart_o, txdData_o,
           overrun_o, int_o
  );

endinterface

// File: rtl/sync_byte_fifo.sv
// First-word-fall-through byte FIFO; a push when full is accepted if a pop drains in the same cycle.
module sync_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic [DEPTH_LOG2:0] count,
  output logic              full,
  output logic              empty
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// RX/TX byte buffering between the UART PHYs and serial_ctrl, with overrun flag and TX pacing FSM.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2_DEFAULT
) (
  input logic        clk25,
  input logic        rst,
  uart_fifo_if.slave bus
);
  logic              rx_full;
  logic              rx_empty;
  logic              rx_drop;
  logic              tx_full;
  logic              tx_empty;
  logic              tx_pop;
  logic [BYTE_W-1:0] tx_head;
  tx_state_e         state;
  logic              start_q;
  logic [BYTE_W-1:0] txd_q;
  logic              overrun_q;

  sync_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk25),
    .rst   (rst),
    .push  (bus.rxdReady_i),
    .din   (bus.rxdData_i),
    .pop   (bus.rxPop_i),
    .dout  (bus.rxData_o),
    .count (bus.rxCount_o),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk25),
    .rst   (rst),
    .push  (bus.txPush_i),
    .din   (bus.txData_i),
    .pop   (tx_pop),
    .dout  (tx_head),
    .count (bus.txCount_o),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // A full RX FIFO only drops the byte if nothing is popped in the same cycle.
  assign rx_drop = bus.rxdReady_i && rx_full && !bus.rxPop_i;
  assign tx_pop  = (state == ST_IDLE) && !tx_empty && !bus.txdBusy_i;

  always_ff @(posedge clk25) begin
    if (rst) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      txd_q     <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      if (rx_drop)            overrun_q <= 1'b1;
      else if (bus.ovClear_i) overrun_q <= 1'b0;

      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_pop) begin
            txd_q   <= tx_head;
            start_q <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: state <= ST_GUARD;
        ST_GUARD: state <= ST_DRAIN;
        ST_DRAIN: if (!bus.txdBusy_i) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rxValid_o  = !rx_empty;
  assign bus.txReady_o  = !tx_full;
  assign bus.txdStart_o = start_q;
  assign bus.txdData_o  = txd_q;
  assign bus.overrun_o  = overrun_q;
  assign bus.int_o      = !rx_empty | overrun_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: RX table vectors plus hand-written TX/overrun/reset sequences.
module tb_uart_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  uart_fifo_if #(.DEPTH_LOG2(4)) bus ();

  uart_fifo #(.DEPTH_LOG2(4)) dut (
    .clk25 (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  typedef struct {
    bit       rdy;
    bit [7:0] din;
    bit       pop;
    bit       clr;
    int       exp_cnt;
    bit       exp_valid;
    bit [7:0] exp_data;
    bit       exp_ov;
    bit       exp_int;
  } vec_t;

  vec_t tbl[9];

  // Transmitter model: busy for 100 cycles after each start pulse, plus a manual hold.
  int         busy_cnt = 0;
  bit         hold_busy = 1'b0;
  bit         prev_start = 1'b0;
  int         width_err = 0;
  int         overlap_err = 0;
  logic [7:0] pulse_q[$];

  always @(posedge clk) begin
    #1;
    if (bus.txdStart_o === 1'b1) begin
      if (prev_start) width_err++;
      else begin
        if (busy_cnt != 0) overlap_err++;
        pulse_q.push_back(bus.txdData_o);
        busy_cnt = 100;
      end
    end else if (busy_cnt != 0) busy_cnt--;
    prev_start = (bus.txdStart_o === 1'b1);
    bus.txdBusy_i = hold_busy || (busy_cnt != 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rx_op(input bit rdy, input logic [7:0] d, input bit pop, input bit clr);
    bus.rxdReady_i = rdy;
    bus.rxdData_i  = d;
    bus.rxPop_i    = pop;
    bus.ovClear_i  = clr;
    step();
    bus.rxdReady_i = 1'b0;
    bus.rxPop_i    = 1'b0;
    bus.ovClear_i  = 1'b0;
  endtask

  task automatic tx_push(input logic [7:0] d);
    bus.txPush_i = 1'b1;
    bus.txData_i = d;
    step();
    bus.txPush_i = 1'b0;
  endtask

  initial begin
    int n;
    bus.rxdReady_i = 1'b0;
    bus.rxdData_i  = 8'h00;
    bus.rxPop_i    = 1'b0;
    bus.txPush_i   = 1'b0;
    bus.txData_i   = 8'h00;
    bus.ovClear_i  = 1'b0;

    //                rdy din    pop clr cnt v  data   ov int
    tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b1, 8'h41, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b1, 8'h41, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h42, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h43, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 8'h77, 1'b1, 1'b0, 1, 1'b1, 8'h77, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};

    step();
    step();
    rst = 1'b0;
    chk("rst_rx_valid", int'(bus.rxValid_o), 0);
    chk("rst_rx_data", int'(bus.rxData_o), 8'h00);
    chk("rst_rx_count", int'(bus.rxCount_o), 0);
    chk("rst_tx_count", int'(bus.txCount_o), 0);
    chk("rst_tx_ready", int'(bus.txReady_o), 1);
    chk("rst_txd_start", int'(bus.txdStart_o), 0);
    chk("rst_txd_data", int'(bus.txdData_o), 8'h00);
    chk("rst_overrun", int'(bus.overrun_o), 0);
    chk("rst_int", int'(bus.int_o), 0);
    step();
    chk("idle_int", int'(bus.int_o), 0);

    for (int i = 0; i < 9; i++) begin
      rx_op(tbl[i].rdy, tbl[i].din, tbl[i].pop, tbl[i].clr);
      chk($sformatf("vec%0d_count", i), int'(bus.rxCount_o), tbl[i].exp_cnt);
      chk($sformatf("vec%0d_valid", i), int'(bus.rxValid_o), int'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_data", i), int'(bus.rxData_o), int'(tbl[i].exp_data));
      chk($sformatf("vec%0d_ov", i), int'(bus.overrun_o), int'(tbl[i].exp_ov));
      chk($sformatf("vec%0d_int", i), int'(bus.int_o), int'(tbl[i].exp_int));
    end

    // RX overrun: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) begin
      rx_op(1'b1, 8'(i), 1'b0, 1'b0);
      if (i < 16) chk($sformatf("ovf_count%0d", i), int'(bus.rxCount_o), i + 1);
    end
    chk("ovf_count_full", int'(bus.rxCount_o), 16);
    chk("ovf_flag", int'(bus.overrun_o), 1);
    chk("ovf_head", int'(bus.rxData_o), 8'h00);
    rx_op(1'b1, 8'h55, 1'b0, 1'b1);
    chk("ovf_set_beats_clear", int'(bus.overrun_o), 1);
    chk("ovf_count_after_drop", int'(bus.rxCount_o), 16);
    rx_op(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", int'(bus.overrun_o), 0);
    chk("ovf_int_from_valid", int'(bus.int_o), 1);

    // Full with simultaneous push+pop: 00 leaves, AA joins at the tail.
    rx_op(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("full_pp_count", int'(bus.rxCount_o), 16);
    chk("full_pp_ov", int'(bus.overrun_o), 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain_head%0d", k), int'(bus.rxData_o), (k < 15) ? k + 1 : 8'hAA);
      rx_op(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_valid", int'(bus.rxValid_o), 0);
    chk("drain_data", int'(bus.rxData_o), 8'h00);
    chk("drain_int", int'(bus.int_o), 0);

    // TX: two bytes paced by the 100-cycle transmitter model.
    tx_push(8'h55);
    chk("tx_count_after_push", int'(bus.txCount_o), 1);
    chk("tx_no_start_yet", int'(bus.txdStart_o), 0);
    step();
    chk("tx_start1", int'(bus.txdStart_o), 1);
    chk("tx_data1", int'(bus.txdData_o), 8'h55);
    chk("tx_count_popped", int'(bus.txCount_o), 0);
    tx_push(8'hAA);
    chk("tx_start_low", int'(bus.txdStart_o), 0);
    chk("tx_count_queued", int'(bus.txCount_o), 1);
    chk("tx_data_held", int'(bus.txdData_o), 8'h55);
    n = 0;
    while (pulse_q.size() < 2 && n < 400) begin step(); n++; end
    step();
    chk("tx_pulse_count", pulse_q.size(), 2);
    if (pulse_q.size() == 2) begin
      chk("tx_pulse0_data", int'(pulse_q[0]), 8'h55);
      chk("tx_pulse1_data", int'(pulse_q[1]), 8'hAA);
    end
    chk("tx_width_err", width_err, 0);
    chk("tx_overlap_err", overlap_err, 0);
    chk("tx_count_zero", int'(bus.txCount_o), 0);
    n = 0;
    while (busy_cnt != 0 && n < 200) begin step(); n++; end
    chk("tx_busy_settled", busy_cnt, 0);

    // TX full: 17 pushes while transmitter is held busy.
    hold_busy = 1'b1;
    step();
    pulse_q.delete();
    for (int i = 0; i < 17; i++) begin
      tx_push(8'(8'h10 + i));
      if (i == 15) chk("txfull_ready_low", int'(bus.txReady_o), 0);
    end
    chk("txfull_count", int'(bus.txCount_o), 16);
    chk("txfull_no_pulse", pulse_q.size(), 0);
    hold_busy = 1'b0;
    n = 0;
    while (pulse_q.size() < 16 && n < 2500) begin step(); n++; end
    chk("txfull_pulse_count", pulse_q.size(), 16);
    for (int k = 0; k < 16; k++)
      if (k < pulse_q.size()) chk($sformatf("txfull_byte%0d", k), int'(pulse_q[k]), 8'h10 + k);
    n = 0;
    while (busy_cnt != 0 && n < 200) begin step(); n++; end
    for (int i = 0; i < 5; i++) step();
    chk("txfull_17th_dropped", pulse_q.size(), 16);
    chk("txfull_count_zero", int'(bus.txCount_o), 0);
    chk("txfull_width_err", width_err, 0);
    chk("txfull_overlap_err", overlap_err, 0);

    // Reset mid-drain: no pulses after the first.
    hold_busy = 1'b1;
    step();
    tx_push(8'hA0);
    tx_push(8'hA1);
    tx_push(8'hA2);
    pulse_q.delete();
    hold_busy = 1'b0;
    n = 0;
    while (pulse_q.size() < 1 && n < 50) begin step(); n++; end
    chk("rstmid_first_pulse", pulse_q.size(), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_start_low", int'(bus.txdStart_o), 0);
    chk("rstmid_tx_count", int'(bus.txCount_o), 0);
    chk("rstmid_tx_ready", int'(bus.txReady_o), 1);
    for (int i = 0; i < 300; i++) step();
    chk("rstmid_no_more_pulses", pulse_q.size(), 1);
    if (pulse_q.size() >= 1) chk("rstmid_pulse_data", int'(pulse_q[0]), 8'hA0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Byte-buffering stage between the UART PHY pair (async_receiver / async_transmitter, 9600 baud at 25 MHz) and serial_ctrl. Absorbs received bytes into an RX FIFO so the CPU can fall behind by up to DEPTH characters without loss. Queues CPU-written bytes in a TX FIFO and paces them onto the transmitter without CPU polling of txdBusy. Provides level counts, a sticky overrun flag and an interrupt request for serial_ctrl.

## Interface
- DEPTH_LOG2, default 4: log2 of entries per FIFO (16); legal range 2..8.
- clk25  in  1  25 MHz system clock.
- rst  in  1  reset, synchronous, active-high.
- rxdReady_i  in  1  one-cycle pulse from async_receiver: byte available.
- rxdData_i  in  8  received byte, valid with rxdReady_i.
- rxPop_i  in  1  consumer removes RX head this cycle.
- rxData_o  out  8  RX head byte (first-word-fall-through); 8'h00 when empty.
- rxValid_o  out  1  RX FIFO non-empty.
- rxCount_o  out  DEPTH_LOG2+1  RX occupancy, 0..DEPTH.
- txPush_i  in  1  consumer writes txData_i into TX FIFO.
- txData_i  in  8  byte to send.
- txReady_o  out  1  TX FIFO not full.
- txCount_o  out  DEPTH_LOG2+1  TX occupancy, 0..DEPTH.
- txdBusy_i  in  1  async_transmitter busy.
- txdStart_o  out  1  one-cycle start pulse to async_transmitter.
- txdData_o  out  8  byte to async_transmitter.
- ovClear_i  in  1  clears overrun_o.
- overrun_o  out  1  sticky: an RX byte was dropped because RX FIFO was full.
- int_o  out  1  rxValid_o | overrun_o.

## Operation
- Both FIFOs: circular buffer, read/write pointers DEPTH_LOG2 bits wrapping modulo DEPTH, occupancy counter DEPTH_LOG2+1 bits.
- RX push on rxdReady_i. Accepted if count < DEPTH, or count == DEPTH and an accepted pop occurs in the same cycle. Otherwise the byte is discarded, count unchanged, overrun_o set.
- RX pop accepted only when rxValid_o; pop on empty is ignored. On empty, simultaneous push+pop: push accepted, pop ignored, count becomes 1.
- overrun_o: set-priority over ovClear_i in the same cycle; held until ovClear_i.
- TX push accepted when txReady_o, or when full with a same-cycle drain pop. Otherwise ignored, with no flag.
- TX drain FSM:
  - IDLE: if txCount_o != 0 and !txdBusy_i: latch head into txdData_o, pop TX FIFO, go START.
  - START: txdStart_o = 1 for exactly this cycle; go GUARD.
  - GUARD: one cycle, covers transmitter busy latency; go DRAIN.
  - DRAIN: wait until txdBusy_i == 0, then go IDLE.
- txdData_o holds stable from START until the next latch.
- int_o is registered-free OR of registered signals, i.e. glitch-free.

## Timing
- Reset values: rxValid_o 0, rxData_o 8'h00, rxCount_o 0, txCount_o 0, txReady_o 1, txdStart_o 0, txdData_o 8'h00, overrun_o 0, int_o 0, FSM IDLE. FIFO storage is not reset.
- RX: a byte pushed at edge N appears on rxData_o/rxValid_o after edge N (visible in cycle N+1). A pop at edge N shows the next head after edge N.
- TX: a byte pushed into an empty FIFO with transmitter idle at edge N gives FSM IDLE→START at edge N+1 and txdStart_o high during cycle N+1.
- Minimum spacing between txdStart_o pulses: 3 cycles plus the transmitter busy time.
- rst mid-operation: both FIFOs emptied, the FSM returns to IDLE, and txdStart_o is deasserted the next cycle. A byte already in the transmitter finishes on its own.
- Counts update in the same edge as the push/pop that caused them.

## Structure
- Shared package uart_pkg:
  - UART_FIFO_DEPTH_LOG2_DEFAULT = 4.
  - TX FSM state encodings: ST_IDLE = 2'd0, ST_START = 2'd1, ST_GUARD = 2'd2, ST_DRAIN = 2'd3.
- Sub-module sync_byte_fifo: parameter DEPTH_LOG2; push/pop/data/count/full/empty with the push-when-full-with-pop rule. Instantiated twice (RX, TX).
- uart_fifo: the two instances, the overrun flag logic and the TX FSM.

## Test plan
- Reset then idle: all outputs at reset values; txReady_o = 1, int_o = 0.
- RX: pulse rxdReady_i with 8'h41, 8'h42, 8'h43.
  - Expect rxCount_o = 3, rxData_o = 8'h41, int_o = 1.
  - Pop ×3 → 8'h42, 8'h43, then rxValid_o = 0, rxData_o = 8'h00.
- RX overrun: push 17 bytes 8'h00..8'h10 with no pop.
  - Expect rxCount_o = 16 and overrun_o = 1; draining yields 8'h00..8'h0F.
  - ovClear_i clears overrun_o; a simultaneous new overrun keeps it set.
- RX full with simultaneous push+pop: count stays 16, the new byte is last out; on empty, simultaneous push+pop gives count 1.
- TX: push 8'h55, 8'hAA with a transmitter model holding busy 100 cycles after start.
  - Exactly two txdStart_o pulses, one cycle each, carrying 8'h55 then 8'hAA.
  - Second pulse only after busy falls; txCount_o returns to 0.
- TX full: push 17 bytes while busy held high. txReady_o = 0 after the 16th, the 17th is ignored, and 16 bytes are later emitted in order. Asserting rst mid-drain stops further txdStart_o pulses.
